// File: rtl/rvfi_check_sequencer.sv
// Sequences one formal instruction-check run: hold the core in reset, count
// retirements across all RVFI channels, and strobe check on the chosen one.
module rvfi_check_sequencer #(
  parameter int NRET         = 1,
  parameter int RESET_CYCLES = 1,
  parameter int SKIP_INSNS   = 0,
  parameter int MAX_WAIT     = 20,
  parameter int CNT_W        = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [NRET-1:0]  rvfi_valid,
  input  logic [NRET-1:0]  rvfi_halt,
  output logic             core_reset,
  output logic             check,
  output logic [NRET-1:0]  check_chan,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);

  localparam int RC_EFF = (RESET_CYCLES < 1) ? 1 : RESET_CYCLES;
  localparam int RC_W   = $clog2(RC_EFF + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_ARMED = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [RC_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             core_reset_q, core_reset_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             halted_q, halted_d;

  logic [31:0]      n_ret, sum, k, seen, wait_next;
  logic [NRET-1:0]  sel;
  logic             armed, hit, halt_any, wait_hit;

  // Sums are kept 32 bits wide so a saturated retired_count cannot hide a hit.
  always_comb begin
    n_ret = '0;
    for (int i = 0; i < NRET; i++) n_ret = n_ret + 32'(rvfi_valid[i]);
    armed     = (state_q == S_ARMED);
    sum       = 32'(ret_q) + n_ret;
    hit       = armed && (sum > $unsigned(32'(SKIP_INSNS)));
    halt_any  = |(rvfi_valid & rvfi_halt);
    wait_next = 32'(wait_q) + 32'd1;
    wait_hit  = $signed(wait_next) >= 32'(MAX_WAIT);
    k         = $unsigned(32'(SKIP_INSNS)) - 32'(ret_q);
  end

  // Pick the k-th set bit of rvfi_valid, counting from channel 0.
  always_comb begin
    sel  = '0;
    seen = '0;
    for (int i = 0; i < NRET; i++) begin
      if (rvfi_valid[i]) begin
        if (seen == k) sel[i] = 1'b1;
        seen = seen + 32'd1;
      end
    end
  end

  assign check      = reset && hit;
  assign check_chan = check ? sel : '0;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    ret_d     = ret_q;
    wait_d    = wait_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    halted_d  = halted_q;
    case (state_q)
      S_IDLE: if (enable) begin
        state_d = S_HOLD;
        cyc_d   = RC_W'(RC_EFF);
      end
      S_HOLD: begin
        if (cyc_q == RC_W'(1)) begin
          state_d = S_ARMED;
          ret_d   = '0;
          wait_d  = '0;
        end else begin
          cyc_d = cyc_q - RC_W'(1);
        end
      end
      S_ARMED: begin
        ret_d  = (sum > 32'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
        wait_d = (wait_q == CNT_MAX) ? wait_q : wait_q + CNT_W'(1);
        if (hit) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (halt_any) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          halted_d = 1'b1;
        end else if (wait_hit) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
    core_reset_d = (state_d == S_IDLE) || (state_d == S_HOLD);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      ret_q        <= '0;
      wait_q       <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      ret_q        <= ret_d;
      wait_q       <= wait_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      halted_q     <= halted_d;
    end
  end

  assign core_reset    = core_reset_q;
  assign busy          = (state_q == S_HOLD) || (state_q == S_ARMED);
  assign done          = done_q;
  assign timeout       = timeout_q;
  assign halted        = halted_q;
  assign retired_count = ret_q;

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Bench for rvfi_check_sequencer: stimulus pushes expected check/done events,
// per-instance monitors pop and compare them as the DUTs present them.
module tb_rvfi_check_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en0, en1, mon_on;
  logic [1:0] valid, halt;

  logic       cr0, chk0, busy0, done0, to0, ha0;
  logic [1:0] ch0;
  logic [7:0] rc0;
  logic       cr1, chk1, busy1, done1, to1, ha1;
  logic [1:0] ch1;
  logic [1:0] rc1;

  rvfi_check_sequencer #(.NRET(2), .RESET_CYCLES(2), .SKIP_INSNS(2), .MAX_WAIT(5), .CNT_W(8)) u0 (
    .clock(clk), .reset(reset), .enable(en0), .rvfi_valid(valid), .rvfi_halt(halt),
    .core_reset(cr0), .check(chk0), .check_chan(ch0), .busy(busy0), .done(done0),
    .timeout(to0), .halted(ha0), .retired_count(rc0));

  // Zero reset cycles (clamped to one) and a 2-bit counter that saturates on the hit.
  rvfi_check_sequencer #(.NRET(2), .RESET_CYCLES(0), .SKIP_INSNS(3), .MAX_WAIT(20), .CNT_W(2)) u1 (
    .clock(clk), .reset(reset), .enable(en1), .rvfi_valid(valid), .rvfi_halt(halt),
    .core_reset(cr1), .check(chk1), .check_chan(ch1), .busy(busy1), .done(done1),
    .timeout(to1), .halted(ha1), .retired_count(rc1));

  typedef struct packed {
    logic       kind;  // 0: check strobe, 1: done rising
    logic [1:0] chan;
    logic       to;
    logic       ha;
    logic [7:0] rc;
  } ev_t;

  ev_t q0[$], q1[$];
  int  pass_cnt = 0, total = 0;

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cyc(input logic [1:0] v, input logic [1:0] h);
    valid = v;
    halt  = h;
    @(posedge clk);
    #1;
  endtask

  function automatic ev_t ev_chk(input logic [1:0] c);
    ev_t e = '0;
    e.chan = c;
    return e;
  endfunction

  function automatic ev_t ev_done(input logic t, input logic h, input logic [7:0] r);
    ev_t e = '0;
    e.kind = 1'b1; e.to = t; e.ha = h; e.rc = r;
    return e;
  endfunction

  // Monitor for u0
  logic dprev0 = 1'b0;
  ev_t  e0;
  always @(negedge clk) if (mon_on) begin
    if (chk0) begin
      if (q0.size() == 0) cmp("u0 unexpected check", 1, 0);
      else begin
        e0 = q0.pop_front();
        cmp("u0 event kind (check)", int'(e0.kind), 0);
        cmp("u0 check_chan", int'(ch0), int'(e0.chan));
      end
    end else cmp("u0 check_chan idle", int'(ch0), 0);
    if (done0 && !dprev0) begin
      if (q0.size() == 0) cmp("u0 unexpected done", 1, 0);
      else begin
        e0 = q0.pop_front();
        cmp("u0 event kind (done)", int'(e0.kind), 1);
        cmp("u0 timeout", int'(to0), int'(e0.to));
        cmp("u0 halted", int'(ha0), int'(e0.ha));
        cmp("u0 retired_count", int'(rc0), int'(e0.rc));
      end
    end
    dprev0 = done0;
  end

  // Monitor for u1
  logic dprev1 = 1'b0;
  ev_t  e1;
  always @(negedge clk) if (mon_on) begin
    if (chk1) begin
      if (q1.size() == 0) cmp("u1 unexpected check", 1, 0);
      else begin
        e1 = q1.pop_front();
        cmp("u1 event kind (check)", int'(e1.kind), 0);
        cmp("u1 check_chan", int'(ch1), int'(e1.chan));
      end
    end else cmp("u1 check_chan idle", int'(ch1), 0);
    if (done1 && !dprev1) begin
      if (q1.size() == 0) cmp("u1 unexpected done", 1, 0);
      else begin
        e1 = q1.pop_front();
        cmp("u1 event kind (done)", int'(e1.kind), 1);
        cmp("u1 timeout", int'(to1), int'(e1.to));
        cmp("u1 halted", int'(ha1), int'(e1.ha));
        cmp("u1 retired_count", int'(rc1), int'(e1.rc));
      end
    end
    dprev1 = done1;
  end

  task automatic chk_reset_state();
    cmp("rst core_reset", int'(cr0), 1);
    cmp("rst busy", int'(busy0), 0);
    cmp("rst done", int'(done0), 0);
    cmp("rst timeout", int'(to0), 0);
    cmp("rst halted", int'(ha0), 0);
    cmp("rst retired_count", int'(rc0), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(2'b00, 2'b00);
    reset = 1'b1;
    chk_reset_state();
  endtask

  // IDLE(enable) + two HOLD cycles, then ARMED with core_reset low.
  task automatic arm0();
    en0 = 1'b1;
    cyc(2'b00, 2'b00);
    en0 = 1'b0;
    cmp("arm0 core_reset c0", int'(cr0), 1);
    cmp("arm0 busy c0", int'(busy0), 1);
    cyc(2'b00, 2'b00);
    cmp("arm0 core_reset c1", int'(cr0), 1);
    cyc(2'b00, 2'b00);
    cmp("arm0 core_reset armed", int'(cr0), 0);
    cmp("arm0 busy armed", int'(busy0), 1);
  endtask

  initial begin
    reset = 1'b0; en0 = 1'b0; en1 = 1'b0; valid = '0; halt = '0; mon_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b1;
    chk_reset_state();
    cmp("rst check", int'(chk0), 0);
    reset = 1'b1;

    // Target is the third retirement: 2 then 2 -> chan 0 on the second beat.
    arm0();
    cyc(2'b00, 2'b00);
    cyc(2'b11, 2'b00);
    q0.push_back(ev_chk(2'b01));
    q0.push_back(ev_done(1'b0, 1'b0, 8'd4));
    cyc(2'b11, 2'b00);
    cyc(2'b00, 2'b00);
    cmp("run1 done", int'(done0), 1);
    cmp("run1 busy", int'(busy0), 0);
    cmp("run1 core_reset", int'(cr0), 0);
    en0 = 1'b1;
    cyc(2'b11, 2'b00);
    en0 = 1'b0;
    cmp("done ignores enable", int'(busy0), 0);
    cmp("done held", int'(done0), 1);

    // 1 retired, then 2 -> target is the second set bit.
    do_reset();
    arm0();
    cyc(2'b01, 2'b00);
    q0.push_back(ev_chk(2'b10));
    q0.push_back(ev_done(1'b0, 1'b0, 8'd3));
    cyc(2'b11, 2'b00);
    cyc(2'b00, 2'b00);

    // Timeout after exactly five ARMED cycles.
    do_reset();
    arm0();
    q0.push_back(ev_done(1'b1, 1'b0, 8'd0));
    repeat (4) cyc(2'b00, 2'b00);
    cmp("timeout not early", int'(done0), 0);
    cyc(2'b00, 2'b00);
    cmp("timeout done", int'(done0), 1);
    cmp("timeout flag", int'(to0), 1);

    // Halt before the target.
    do_reset();
    arm0();
    q0.push_back(ev_done(1'b0, 1'b1, 8'd1));
    cyc(2'b01, 2'b01);
    cyc(2'b00, 2'b00);
    cmp("halt early flag", int'(ha0), 1);

    // Halt on the target itself still checks.
    do_reset();
    arm0();
    cyc(2'b11, 2'b00);
    q0.push_back(ev_chk(2'b01));
    q0.push_back(ev_done(1'b0, 1'b0, 8'd3));
    cyc(2'b01, 2'b01);
    cyc(2'b00, 2'b00);
    cmp("halt on target halted", int'(ha0), 0);

    // Reset on the target cycle suppresses check and returns to IDLE.
    do_reset();
    arm0();
    cyc(2'b11, 2'b00);
    reset = 1'b0;
    cyc(2'b11, 2'b00);
    reset = 1'b1;
    chk_reset_state();
    arm0();
    cyc(2'b01, 2'b00);
    q0.push_back(ev_chk(2'b10));
    q0.push_back(ev_done(1'b0, 1'b0, 8'd3));
    cyc(2'b11, 2'b00);
    cyc(2'b00, 2'b00);

    // u1: single HOLD cycle, 2+2 > 3 with counter saturating at 3.
    do_reset();
    en1 = 1'b1;
    cyc(2'b00, 2'b00);
    en1 = 1'b0;
    cmp("u1 core_reset hold", int'(cr1), 1);
    cyc(2'b00, 2'b00);
    cmp("u1 core_reset armed", int'(cr1), 0);
    cmp("u1 busy armed", int'(busy1), 1);
    cyc(2'b11, 2'b00);
    q1.push_back(ev_chk(2'b10));
    q1.push_back(ev_done(1'b0, 1'b0, 8'd3));
    cyc(2'b11, 2'b00);
    repeat (3) cyc(2'b00, 2'b00);

    cmp("u0 events drained", q0.size(), 0);
    cmp("u1 events drained", q1.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total);
    $fatal(1);
  end

endmodule
